// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/subtract unit with its carry chain cut into STAGES registered
// chunks, valid/ready flow control on both sides. Optional ovf output: define ADDER_PIPE_OVF_EN.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef ADDER_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             valid_out,
  input  logic             ready_out
);

  localparam int CW = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is folded into the operands here; bubbles enter as all-zero data.
  always_comb begin
    a_eff   = '0;
    b_eff   = '0;
    cin_eff = 1'b0;
    if (valid_in) begin
      a_eff   = a;
      b_eff   = sub ? ~b : b;
      cin_eff = sub ? ~c_in : c_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      localparam int LO_W = (gi + 1) * CW;
      localparam int HI_W = WIDTH - LO_W;

      logic [CW-1:0]   a_chunk;
      logic [CW-1:0]   b_chunk;
      logic            carry_in;
      logic            valid_src;
      logic [CW:0]     chunk_res;
      logic [LO_W-1:0] sum_lo_d;
      logic [LO_W-1:0] sum_lo_q;
      logic            carry_d;
      logic            carry_q;
      logic            valid_d;
      logic            valid_q;

      if (gi == 0) begin : gen_src
        always_comb begin
          a_chunk   = a_eff[CW-1:0];
          b_chunk   = b_eff[CW-1:0];
          carry_in  = cin_eff;
          valid_src = valid_in;
          sum_lo_d  = chunk_res[CW-1:0];
        end
      end else begin : gen_src
        // Lowest chunk still waiting in the previous stage's skew registers.
        always_comb begin
          a_chunk   = gen_stage[gi-1].gen_skew.a_hi_q[CW-1:0];
          b_chunk   = gen_stage[gi-1].gen_skew.b_hi_q[CW-1:0];
          carry_in  = gen_stage[gi-1].carry_q;
          valid_src = gen_stage[gi-1].valid_q;
          sum_lo_d  = {chunk_res[CW-1:0], gen_stage[gi-1].sum_lo_q};
        end
      end

      always_comb begin
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CW{1'b0}}, carry_in};
        carry_d   = chunk_res[CW];
        valid_d   = valid_src;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_lo_q <= '0;
          carry_q  <= 1'b0;
          valid_q  <= 1'b0;
        end else if (advance) begin
          sum_lo_q <= sum_lo_d;
          carry_q  <= carry_d;
          valid_q  <= valid_d;
        end
      end

      if (HI_W > 0) begin : gen_skew
        logic [HI_W-1:0] a_hi_d;
        logic [HI_W-1:0] a_hi_q;
        logic [HI_W-1:0] b_hi_d;
        logic [HI_W-1:0] b_hi_q;

        if (gi == 0) begin : gen_load
          always_comb begin
            a_hi_d = a_eff[WIDTH-1:CW];
            b_hi_d = b_eff[WIDTH-1:CW];
          end
        end else begin : gen_load
          always_comb begin
            a_hi_d = gen_stage[gi-1].gen_skew.a_hi_q[HI_W+CW-1:CW];
            b_hi_d = gen_stage[gi-1].gen_skew.b_hi_q[HI_W+CW-1:CW];
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            a_hi_q <= '0;
            b_hi_q <= '0;
          end else if (advance) begin
            a_hi_q <= a_hi_d;
            b_hi_q <= b_hi_d;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    sum       = gen_stage[STAGES-1].sum_lo_q;
    c_out     = gen_stage[STAGES-1].carry_q;
    valid_out = gen_stage[STAGES-1].valid_q;
    advance   = ~gen_stage[STAGES-1].valid_q | ready_out;
    ready_in  = advance;
  end

`ifdef ADDER_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  always_comb begin
    ovf_d = gen_stage[STAGES-1].chunk_res[CW]
          ^ (gen_stage[STAGES-1].chunk_res[CW-1]
             ^ gen_stage[STAGES-1].a_chunk[CW-1]
             ^ gen_stage[STAGES-1].b_chunk[CW-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed latency/arithmetic cases plus random streams checked
// against an integer-arithmetic reference with a result queue.
module tb_adder_pipe;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             valid_out;
  logic             ready_out;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } res_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  res_t exp_q[$];

  logic             stalled = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic             held_c;
  logic             held_o;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .sum       (sum),
    .c_out     (c_out),
`ifdef ADDER_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  // Reference: exact integer arithmetic, then reduce to WIDTH bits / carry / signed range.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic sb);
    longint ux, uy, sx, sy, r, sr;
    res_t   m;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      r   = ux - uy - longint'(ci);
      sr  = sx - sy - longint'(ci);
      m.c = (r >= 0);
    end else begin
      r   = ux + uy + longint'(ci);
      sr  = sx + sy + longint'(ci);
      m.c = (r >= (longint'(1) << WIDTH));
    end
    m.s = WIDTH'(r);
    m.o = (sr > ((longint'(1) << (WIDTH-1)) - 1)) || (sr < -(longint'(1) << (WIDTH-1)));
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One streaming cycle: inputs already driven; sample, score, then advance past the edge.
  task automatic tick(output logic acc);
    res_t r;
    #1;
    check("ready_in", ready_in, !(valid_out && !ready_out));
    if (stalled) begin
      check("stall_valid", valid_out, 1);
      check("stall_sum", sum, held_sum);
      check("stall_cout", c_out, held_c);
`ifdef ADDER_PIPE_OVF_EN
      check("stall_ovf", ovf, held_o);
`endif
    end
    acc = valid_in && ready_in;
    if (acc) exp_q.push_back(model(a, b, c_in, sub));
    if (valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", valid_out, 0);
      end else begin
        r = exp_q.pop_front();
        n_out++;
        check("stream_sum", sum, r.s);
        check("stream_cout", c_out, r.c);
`ifdef ADDER_PIPE_OVF_EN
        check("stream_ovf", ovf, r.o);
`endif
        $display("[TB] out #%0d sum=%h c_out=%b (exp %h/%b)", n_out, sum, c_out, r.s, r.c);
      end
    end
    stalled  = valid_out && !ready_out;
    held_sum = sum;
    held_c   = c_out;
`ifdef ADDER_PIPE_OVF_EN
    held_o   = ovf;
`else
    held_o   = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  // Single beat into an empty pipe; result must appear after exactly STAGES edges.
  task automatic directed(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input logic xs,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    a = xa; b = xb; c_in = xc; sub = xs; valid_in = 1'b1; ready_out = 1'b1;
    #1;
    check({tag, "_ready_in"}, ready_in, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    for (int k = 1; k < STAGES; k++) begin
      check({tag, "_early_valid"}, valid_out, 0);
      @(posedge clk);
      #1;
    end
    check({tag, "_valid"}, valid_out, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, c_out, ec);
`ifdef ADDER_PIPE_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo) $display("[TB] %s expects ovf=1 (port not built)", tag);
`endif
    $display("[TB] %s a=%h b=%h c_in=%b sub=%b -> sum=%h c_out=%b", tag, xa, xb, xc, xs, sum, c_out);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       acc;
    int         sent;
    int         base;
    logic [7:0] pat;

    // Reset held two cycles with a valid beat offered.
    rst = 1'b1; valid_in = 1'b1; a = 16'h1234; b = 16'h0001; c_in = 1'b0; sub = 1'b0;
    ready_out = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", c_out, 0);
`ifdef ADDER_PIPE_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0; valid_in = 1'b0;
    #1;
    check("rst_ready_in", ready_in, 1);
    @(posedge clk);
    #1;

    directed("add_chunk_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed("add_wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub_borrow",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_borrow_in",   16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
    directed("ovf_add",         16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_sub",         16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("no_ovf",          16'h0003, 16'h0002, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back beats, ready_out pattern 1,0,0,1,0,1,1,0 repeating.
    pat  = 8'b0110_1001;
    sent = 0;
    base = n_out;
    for (int cyc = 0; cyc < 200 && (sent < 8 || exp_q.size() > 0); cyc++) begin
      valid_in  = (sent < 8);
      a         = WIDTH'(sent);
      b         = 16'h1000;
      c_in      = 1'b0;
      sub       = 1'b0;
      ready_out = pat[cyc % 8];
      tick(acc);
      if (acc) sent++;
    end
    check("bp_sent", sent, 8);
    check("bp_drained", exp_q.size(), 0);
    check("bp_count", n_out - base, 8);

    // Random operands, random valid_in and ready_out.
    sent = 0;
    base = n_out;
    for (int cyc = 0; cyc < 400 && (sent < 40 || exp_q.size() > 0); cyc++) begin
      valid_in  = (sent < 40) && ($urandom_range(0, 3) != 0);
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      c_in      = 1'($urandom);
      sub       = 1'($urandom);
      ready_out = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) sent++;
    end
    check("rand_sent", sent, 40);
    check("rand_drained", exp_q.size(), 0);
    check("rand_count", n_out - base, 40);

    // Reset with two beats in flight; they must never emerge.
    ready_out = 1'b1;
    stalled   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'b0; sub = 1'b0;
      tick(acc);
    end
    check("mid_accepted", exp_q.size(), 2);
    rst = 1'b1; valid_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; valid_in = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", valid_out, 0);
    for (int i = 0; i < STAGES + 2; i++) begin
      check("mid_no_stale", valid_out, 0);
      tick(acc);
    end
    directed("post_rst", 16'h0042, 16'h0011, 1'b0, 1'b0, 16'h0053, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
